// File: rtl/bmult_col_acc_if.sv
// Product-in / limb-out bus of the column accumulator.
// The accumulator takes the slave side; the upstream sequencer (or a bench) takes the master side.
interface bmult_col_acc_if #(
    parameter int LIMB_W = 20
) ();
    // Handshake: a product is consumed on every rising edge where p_valid=1 and busy=0.
    // There is no back-pressure on the limb side: limb_valid is a one-cycle pulse and
    // the consumer must take the limb in that cycle.
    logic [2*LIMB_W-1:0] p_in;
    logic                p_valid;
    logic                col_end;
    logic                last;
    logic                busy;
    logic [LIMB_W-1:0]   limb_out;
    logic                limb_valid;
    logic                limb_last;

    modport master (
        output p_in, p_valid, col_end, last,
        input  busy, limb_out, limb_valid, limb_last
    );

    modport slave (
        input  p_in, p_valid, col_end, last,
        output busy, limb_out, limb_valid, limb_last
    );
endinterface

// File: rtl/bmult_col_acc.sv
// Column (Comba-order) accumulator behind the 20x20 multiplier: sums partial products per
// column, emits one 20-bit limb per column and a final carry limb in a one-cycle FLUSH.
module bmult_col_acc #(
    parameter int LIMB_W  = 20,
    parameter int GUARD_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bmult_col_acc_if.slave       bus,
    output logic                 ovf,
    output logic                 proto_err,
    output logic [0:0]           dbg_state
);
    localparam int ACC_W = 2*LIMB_W + GUARD_W;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [LIMB_W-1:0] r_limb_out;
    logic              r_limb_valid;
    logic              r_limb_last;
    logic              r_ovf;
    logic              r_proto_err;

    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  w_carry;

    // One extra bit on the sum so a column that exceeds the guard range is detectable.
    assign w_sum   = {1'b0, r_acc} + {{(GUARD_W+1){1'b0}}, bus.p_in};
    assign w_carry = {{(LIMB_W-1){1'b0}}, w_sum[ACC_W:LIMB_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_ACCUM;
            r_acc        <= '0;
            r_limb_out   <= '0;
            r_limb_valid <= 1'b0;
            r_limb_last  <= 1'b0;
            r_ovf        <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_limb_valid <= 1'b0;
            r_limb_last  <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    if (bus.p_valid) begin
                        if (w_sum[ACC_W]) begin
                            r_ovf <= 1'b1;
                        end
                        if (bus.col_end) begin
                            r_limb_out   <= w_sum[LIMB_W-1:0];
                            r_limb_valid <= 1'b1;
                            r_acc        <= w_carry;
                            if (bus.last) begin
                                r_state <= ST_FLUSH;
                            end
                        end else begin
                            r_acc <= w_sum[ACC_W-1:0];
                        end
                    end
                end
                ST_FLUSH: begin
                    // Leftover carry becomes the most significant limb; anything above it is lost.
                    r_limb_out   <= r_acc[LIMB_W-1:0];
                    r_limb_valid <= 1'b1;
                    r_limb_last  <= 1'b1;
                    if (|r_acc[ACC_W-1:LIMB_W]) begin
                        r_ovf <= 1'b1;
                    end
                    if (bus.p_valid) begin
                        r_proto_err <= 1'b1;
                    end
                    r_acc   <= '0;
                    r_state <= ST_ACCUM;
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign bus.busy       = (r_state == ST_FLUSH);
    assign bus.limb_out   = r_limb_out;
    assign bus.limb_valid = r_limb_valid;
    assign bus.limb_last  = r_limb_last;
    assign ovf            = r_ovf;
    assign proto_err      = r_proto_err;
    assign dbg_state      = r_state;
endmodule
